// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: pointer/qualification sequencer for a RAM-backed delay line
// with a runtime-programmable delay. The RAM itself lives outside this block
// (one write port, one synchronous read port, 1-cycle read latency).
// Optional feature: define DELAY_LINE_CTRL_PRIME_ZERO_EN to emit zero-valued
// samples while the line is still filling.
module delay_line_ctrl #(
    parameter int WIDTH         = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ivalid,
    input  logic [WIDTH-1:0]      idata,
    input  logic                  cfg_load,
    input  logic [ADDR_WIDTH-1:0] cfg_delay,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [WIDTH-1:0]      ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [WIDTH-1:0]      ram_rdata,
    output logic                  ovalid,
    output logic [WIDTH-1:0]      odata,
    output logic                  primed,
    output logic [ADDR_WIDTH-1:0] fill_level,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] DEF_DLY = ADDR_WIDTH'(DEFAULT_DELAY);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0]   dly_q, dly_d;
    logic                    ovalid_q, ovalid_d;
    logic                    cfg_err_q, cfg_err_d;
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
    logic                    zero_q, zero_d;
`endif

    logic                    wr_ev;
    logic [ADDR_WIDTH-1:0]   load_dly;
    logic [ADDR_WIDTH-1:0]   eff_dly;

    // Write event and RAM addressing; a delay loaded this cycle already steers this cycle's read.
    always_comb begin
        load_dly  = (cfg_delay == '0) ? ONE : cfg_delay;
        eff_dly   = cfg_load ? load_dly : dly_q;
        wr_ev     = enable & ivalid & ((state_q == S_FILL) | (state_q == S_RUN));
        ram_wen   = wr_ev & ~reset;
        ram_waddr = wr_ptr_q;
        ram_wdata = idata;
        ram_raddr = wr_ptr_q - eff_dly;
    end

    // Next-state logic: pointer, fill counter, delay register and FSM.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        dly_d      = dly_q;
        cfg_err_d  = cfg_err_q;
        // A load-cycle write is the first write of a fresh fill, so it is never qualified.
        ovalid_d   = wr_ev & (state_q == S_RUN) & ~cfg_load;
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
        ovalid_d   = wr_ev;
        zero_d     = wr_ev & ((state_q == S_FILL) | cfg_load);
`endif
        if (wr_ev) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end

        if (cfg_load) begin
            dly_d = load_dly;
            if (cfg_delay == '0) begin
                cfg_err_d = 1'b1;
            end
            fill_cnt_d = wr_ev ? ONE : '0;
            if (state_q == S_IDLE) begin
                if (enable) begin
                    state_d = S_FILL;
                end
            end else if (wr_ev && (load_dly == ONE)) begin
                state_d = S_RUN;
            end else begin
                state_d = S_FILL;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    if (wr_ev) begin
                        fill_cnt_d = fill_cnt_q + ONE;
                        if ((fill_cnt_q + ONE) == dly_q) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // fill_cnt holds at dly: saturated.
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset also drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            dly_q      <= DEF_DLY;
            ovalid_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            dly_q      <= dly_d;
            ovalid_q   <= ovalid_d;
            cfg_err_q  <= cfg_err_d;
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
            zero_q     <= zero_d;
`endif
        end
    end

    // Output qualification: RAM data is passed only while a qualified read is returning.
    always_comb begin
        ovalid     = ovalid_q;
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
        odata      = (ovalid_q && !zero_q) ? ram_rdata : '0;
`else
        odata      = ovalid_q ? ram_rdata : '0;
`endif
        primed     = (state_q == S_RUN);
        fill_level = fill_cnt_q;
        cfg_err    = cfg_err_q;
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Testbench for delay_line_ctrl: randomized stimulus, a history-based reference
// model, a behavioural RAM, and a scoreboard monitor for ovalid/odata.
module tb_delay_line_ctrl;

    localparam int W  = 32;
    localparam int AW = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, enable, ivalid, cfg_load;
    logic [W-1:0]  idata;
    logic [AW-1:0] cfg_delay;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [W-1:0]  ram_wdata, ram_rdata;
    logic          ovalid, primed, cfg_err;
    logic [W-1:0]  odata;
    logic [AW-1:0] fill_level;

    delay_line_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEFAULT_DELAY(1)) dut (
        .clock(clk), .reset(reset), .enable(enable), .ivalid(ivalid), .idata(idata),
        .cfg_load(cfg_load), .cfg_delay(cfg_delay),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ovalid(ovalid), .odata(odata), .primed(primed),
        .fill_level(fill_level), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Behavioural simple-dual-port RAM with 1-cycle read latency.
    logic [W-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: delay, writes since load, pointer, history of every sample.
    int           m_d = 1;
    int           m_cnt = 0;
    int           m_ptr = 0;
    bit           m_err = 0;
    bit           m_active = 0;
    logic [W-1:0] hist[$];
    bit           mon_en = 0;

    // Scoreboard monitor: an output is due exactly in the cycle stamped by the stimulus.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("ovalid", ovalid, 1);
                check("odata", odata, e.data);
                $display("cycle %0d: out %0h expected %0h", cyc, odata, e.data);
            end else begin
                check("ovalid_quiet", ovalid, 0);
                check("odata_quiet", odata, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_total++;
                    $display("FAIL missed_output: expected output at cycle %0d never appeared", exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit rst, input bit en, input bit iv, input logic [W-1:0] data,
                        input bit load, input int d);
        bit wr;
        int fl;
        reset     = rst;
        enable    = en;
        ivalid    = iv;
        idata     = data;
        cfg_load  = load;
        cfg_delay = d[AW-1:0];
        wr = 0;
        if (!rst) begin
            if (load) begin
                m_d   = (d == 0) ? 1 : d;
                m_err = m_err | (d == 0);
                m_cnt = 0;
            end
            wr = iv && en && m_active;
        end
        #1;
        check("ram_wen", ram_wen, wr);
        if (!rst) begin
            check("ram_waddr", ram_waddr, m_ptr);
            check("ram_raddr", ram_raddr, (m_ptr - m_d) & (DEPTH - 1));
        end
        if (wr) begin
            exp_t e;
            e.cyc = cyc + 1;
            if (m_cnt >= m_d) begin
                e.data = hist[hist.size() - m_d];
                exp_q.push_back(e);
            end else begin
`ifdef DELAY_LINE_CTRL_PRIME_ZERO_EN
                e.data = '0;
                exp_q.push_back(e);
`endif
            end
            hist.push_back(data);
            m_ptr = (m_ptr + 1) & (DEPTH - 1);
            m_cnt++;
        end
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_d = 1; m_err = 0; m_active = 0;
            hist.delete();
        end else if (en) begin
            m_active = 1;
        end
        @(posedge clk);
        mon_en = 1;
        #1;
        fl = (m_cnt < m_d) ? m_cnt : m_d;
        check("fill_level", fill_level, fl);
        check("primed", primed, m_active && (m_cnt >= m_d));
        check("cfg_err", cfg_err, m_err);
    endtask

    initial begin
        reset = 1; enable = 0; ivalid = 0; idata = '0; cfg_load = 0; cfg_delay = '0;

        // Reset held 3 cycles with ivalid high.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'hdead_0000 + i, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // Continuous stream, D=4.
        step(0, 1, 0, 0, 1, 4);
        for (int i = 1; i <= 12; i++) step(0, 1, 1, i, 0, 0);

        // Gapped stream, D=3.
        step(0, 1, 0, 0, 1, 3);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 10 + i, 0, 0);
            step(0, 1, 0, 0, 0, 0);
        end

        // Reconfigure in RUN: D=4 -> D=2 coinciding with a write of 20.
        step(0, 1, 0, 0, 1, 4);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 100 + i, 0, 0);
        step(0, 1, 1, 20, 1, 2);
        for (int i = 21; i <= 26; i++) step(0, 1, 1, i, 0, 0);

        // enable low holds state; load of 0 while disabled still honoured.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hbad0 + i, 0, 0);
        step(0, 0, 1, 32'hbad9, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 200 + i, 0, 0);
        step(0, 1, 0, 0, 1, 5);
        for (int i = 0; i < 12; i++) step(0, 1, 1, $urandom, 0, 0);

        // Reset mid-operation with a write pending.
        step(1, 1, 1, 32'h5555, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 300 + i, 0, 0);

        // Maximum delay across pointer wrap.
        step(0, 1, 0, 0, 1, DEPTH - 1);
        for (int i = 0; i < 1500; i++) step(0, 1, 1, 1000 + i, 0, 0);

        // Randomized phase: gaps, enable drops and occasional reloads.
        for (int i = 0; i < 400; i++)
            step(0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 29) == 0), $urandom_range(0, 12));

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected outputs never appeared", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencer for a RAM-backed, sample-qualified delay line with a runtime-programmable delay. It owns the write and read pointers of an external simple-dual-port RAM (one write port, one synchronous read port, 1-cycle read latency). It tracks how many samples have been written since the last (re)configuration and qualifies the RAM read data as valid only once the line is primed. It sits between a streaming source (`idata`/`ivalid`) and any consumer needing a delay of D samples, replacing fixed-depth delay instances wherever the delay must change at run time.

## Interface
- `WIDTH`, 32, sample width.
- `ADDR_WIDTH`, 9, RAM address width; depth = 2^ADDR_WIDTH.
- `DEFAULT_DELAY`, 1, delay loaded at reset; legal range 1..2^ADDR_WIDTH-1.

- `clock` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: gates `ivalid`; when low, inputs are ignored and state is held.
- `ivalid` in 1: sample strobe.
- `idata` in WIDTH: sample.
- `cfg_load` in 1: one-cycle pulse; latches `cfg_delay`.
- `cfg_delay` in ADDR_WIDTH: requested delay D in samples.
- `ram_wen` out 1: RAM write enable.
- `ram_waddr` out ADDR_WIDTH: RAM write address.
- `ram_wdata` out WIDTH: RAM write data.
- `ram_raddr` out ADDR_WIDTH: RAM read address.
- `ram_rdata` in WIDTH: RAM read data, valid 1 cycle after `ram_raddr`.
- `ovalid` out 1: `odata` holds a delayed sample.
- `odata` out WIDTH: delayed sample; 0 when `ovalid`=0.
- `primed` out 1: high in RUN state.
- `fill_level` out ADDR_WIDTH: writes counted since the last reset/load, saturating at D.
- `cfg_err` out 1: sticky; set when `cfg_delay`=0 is loaded.

## Operation
- Write event: `ivalid & enable` in state FILL or RUN.
- The write path is combinational from registered pointers:
  - `ram_wen` = write event; `ram_waddr` = `wr_ptr`; `ram_wdata` = `idata`.
  - `ram_raddr` = `wr_ptr - dly` (mod 2^ADDR_WIDTH).
- `wr_ptr` increments on each write event and wraps freely at 2^ADDR_WIDTH.
- FSM states:
  - IDLE: entered from reset. Moves to FILL on the first cycle `enable`=1.
  - FILL: each write event increments `fill_cnt`. When a write makes `fill_cnt`=`dly`, the next state is RUN. Reads issued in FILL are never qualified.
  - RUN: each write event issues a qualified read of the sample written `dly` writes earlier.
- `cfg_load` in any state:
  - `dly` takes `cfg_delay`; a value of 0 is clamped to 1 and sets `cfg_err`.
  - `fill_cnt` is cleared and the next state is FILL (IDLE stays IDLE).
  - `wr_ptr` is not reset.
- `cfg_load` together with a write event: the new delay applies to that same cycle's `ram_raddr`, and the sample counts as write 1 under the new delay.
- `enable`=0: no writes, no counter changes, no FSM transitions. `cfg_load` is still honoured.
- `fill_level` = `fill_cnt`; it saturates at `dly` in RUN.

## Timing
- Reset values:
  - `wr_ptr`=0, `fill_cnt`=0, `dly`=`DEFAULT_DELAY`, state IDLE.
  - `ovalid`=0, `odata`=0, `primed`=0, `fill_level`=0, `cfg_err`=0.
  - `ram_wen`=0 while in reset.
- Latency: a write event in RUN at cycle t gives `ovalid`=1 at t+1, with `odata`=`ram_rdata` equal to the sample written D write events earlier.
- `ovalid` is a registered flag: (write event & RUN) from the previous cycle. `odata` is `ram_rdata` gated by `ovalid`.
- A read issued in RUN in the cycle before `cfg_load` still returns `ovalid`=1 in the load cycle.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - Any in-flight read is dropped, so `ovalid`=0 in the cycle after reset.
- D = 2^ADDR_WIDTH-1 is legal. The read address then equals `wr_ptr+1`, so no read/write address collision occurs.

## Configuration
- `DELAY_LINE_CTRL_PRIME_ZERO_EN`
  - Defined: zero-initialised semantics. Every write event in FILL also produces `ovalid`=1 at t+1 with `odata`=0, so output cadence matches input from the first sample. `primed` is unchanged.
  - Undefined: `ovalid` stays 0 until RUN.

## Test plan
- Reset: hold `reset` 3 cycles with `ivalid`=1 -> all outputs 0, `ram_wen`=0 throughout.
- Continuous stream: D=4 via `cfg_load`, `enable`=1, `ivalid`=1 every cycle, `idata`=1,2,3…
  - `ovalid` first rises the cycle after write 5, with `odata`=1.
  - Thereafter `odata` = `idata`−4 every cycle; `primed` rises after write 4.
- Gapped stream: D=3, `ivalid` every other cycle, `idata`=10,11,12,… -> first `ovalid` one cycle after the 4th write with `odata`=10. `ovalid` is never high two cycles in a row.
- Reconfigure in RUN: D=4 to D=2 with `cfg_load` coinciding with a write of value 20:
  - `fill_level`=1 after that edge.
  - `ovalid` low until the 3rd post-load write; the next `odata`=20.
- Error and limits:
  - Load D=0 -> `cfg_err`=1 (sticky through a later legal load), with delay 1.
  - With ADDR_WIDTH=9, load D=511 and stream 1500 samples -> `odata` = `idata`−511 across `wr_ptr` wrap.
- Macro defined, D=4, stream 1.. -> `ovalid`=1 from the cycle after write 1; `odata`=0,0,0,0 then 1,2,…
